// File: rtl/tlv5618_pkg.sv
// Shared constants, command encodings and FSM state type for the TLV5618 serial receiver.
package tlv5618_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 12;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

  // Frame field positions, MSB first on the wire
  localparam int R1_POS  = 15;
  localparam int SPD_POS = 14;
  localparam int PWR_POS = 13;
  localparam int R0_POS  = 12;

  localparam logic [1:0] CMD_B_BUF  = 2'b00;
  localparam logic [1:0] CMD_BUF    = 2'b01;
  localparam logic [1:0] CMD_A_XFER = 2'b10;
  localparam logic [1:0] CMD_CTRL   = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } rx_state_e;

  function automatic logic [1:0] get_cmd(input logic [FRAME_BITS-1:0] w);
    return {w[R1_POS], w[R0_POS]};
  endfunction

endpackage

// File: rtl/tlv5618_rx_sync.sv
// Multi-flop synchronizer with edge detect for the asynchronous serial link pins.
module tlv5618_rx_sync
  import tlv5618_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] rise
);

  // One extra flop beyond the synchronizer holds the previous synced sample
  logic [WIDTH-1:0] chain [SYNC_STAGES+1];
  logic [WIDTH-1:0] prev;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i <= SYNC_STAGES; i++) begin
        chain[i] <= RESET_VAL;
      end
    end else begin
      chain[0] <= async_in;
      for (int i = 1; i <= SYNC_STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign sync_out = chain[SYNC_STAGES-1];
  assign prev     = chain[SYNC_STAGES];
  assign fall     = prev & ~sync_out;
  assign rise     = ~prev & sync_out;

endmodule

// File: rtl/tlv5618_serial_rx.sv
// TLV5618 3-wire DAC link receiver: deserializes frames and models the DAC A/B/buffer registers.
// Optional TLV5618_RX_STATS_EN adds wrapping frame_cnt/err_cnt outputs.
module tlv5618_serial_rx
  import tlv5618_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  dac_cs_n,
  input  logic                  dac_sclk,
  input  logic                  dac_din,
  output logic [FRAME_BITS-1:0] frame_word,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [DATA_W-1:0]     dac_a_code,
  output logic [DATA_W-1:0]     dac_b_code,
  output logic [DATA_W-1:0]     buf_code,
  output logic                  speed_fast,
  output logic                  power_down,
  output logic                  rx_busy
`ifdef TLV5618_RX_STATS_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [7:0]            err_cnt
`endif
);

  // Pin order {din, sclk, cs_n}; idle reset state is CS high, SCLK low
  logic [2:0] pins_sync;
  logic [2:0] pins_fall;
  logic [2:0] pins_rise;

  tlv5618_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .WIDTH       (3),
    .RESET_VAL   (3'b001)
  ) u_sync (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .async_in ({dac_din, dac_sclk, dac_cs_n}),
    .sync_out (pins_sync),
    .fall     (pins_fall),
    .rise     (pins_rise)
  );

  logic cs_fall;
  logic cs_rise;
  logic sclk_fall;
  logic din_s;
  logic sync_unused;

  assign cs_fall     = pins_fall[0];
  assign cs_rise     = pins_rise[0];
  assign sclk_fall   = pins_fall[1];
  assign din_s       = pins_sync[2];
  assign sync_unused = ^{pins_sync[1:0], pins_fall[2], pins_rise[2:1]};

  rx_state_e             state_q;
  rx_state_e             state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_next;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] word_next;
  logic [DATA_W-1:0]     data_next;
  logic                  shift_en;
  logic                  commit;
  logic                  err_set;
  logic                  cnt_clr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An SCLK fall coinciding with CS rise is counted before the CS rise is judged
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    commit    = 1'b0;
    err_set   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_next  = cnt_q + 5'd1;
    word_next = {shift_q[FRAME_BITS-2:0], din_s};
    data_next = word_next[DATA_W-1:0];
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_clr = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_fall) begin
          shift_en = 1'b1;
          if (cnt_next == CNT_FULL) begin
            commit  = 1'b1;
            state_d = WAIT_CS;
          end
        end
        if (cs_rise) begin
          state_d = IDLE;
          if (!commit && (shift_en || (cnt_q != '0))) begin
            err_set = 1'b1;
          end
        end
      end
      WAIT_CS: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_word  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      dac_a_code  <= '0;
      dac_b_code  <= '0;
      buf_code    <= '0;
      speed_fast  <= 1'b0;
      power_down  <= 1'b0;
    end else begin
      frame_valid <= commit;
      frame_err   <= err_set;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (shift_en) begin
        cnt_q <= cnt_next;
      end
      if (shift_en) begin
        shift_q <= word_next;
      end
      // The A-transfer command moves the pre-update buffer into DAC B
      if (commit) begin
        frame_word <= word_next;
        speed_fast <= word_next[SPD_POS];
        power_down <= word_next[PWR_POS];
        case (get_cmd(word_next))
          CMD_B_BUF: begin
            dac_b_code <= data_next;
            buf_code   <= data_next;
          end
          CMD_BUF: begin
            buf_code <= data_next;
          end
          CMD_A_XFER: begin
            dac_a_code <= data_next;
            dac_b_code <= buf_code;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign rx_busy = (state_q != IDLE);

`ifdef TLV5618_RX_STATS_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (commit) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err_set) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tlv5618_serial_rx.sv
// Directed self-checking bench for tlv5618_serial_rx; builds with or without TLV5618_RX_STATS_EN.
module tb_tlv5618_serial_rx;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        dac_cs_n;
  logic        dac_sclk;
  logic        dac_din;
  logic [15:0] frame_word;
  logic        frame_valid;
  logic        frame_err;
  logic [11:0] dac_a_code;
  logic [11:0] dac_b_code;
  logic [11:0] buf_code;
  logic        speed_fast;
  logic        power_down;
  logic        rx_busy;
`ifdef TLV5618_RX_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  tlv5618_serial_rx #(.SYNC_STAGES(2)) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .dac_cs_n    (dac_cs_n),
    .dac_sclk    (dac_sclk),
    .dac_din     (dac_din),
    .frame_word  (frame_word),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .dac_a_code  (dac_a_code),
    .dac_b_code  (dac_b_code),
    .buf_code    (buf_code),
    .speed_fast  (speed_fast),
    .power_down  (power_down),
    .rx_busy     (rx_busy)
`ifdef TLV5618_RX_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int err_seen = 0;
  int exp_frames = 0;
  int exp_errs = 0;
  int valid_base = 0;

  logic [11:0] ref_a, ref_b, ref_buf;
  logic        ref_spd, ref_pwr;
  logic [15:0] ref_word;

  // Pulse monitor, sampled away from the active edge
  always @(negedge sys_clk) begin
    if (frame_valid === 1'b1) valid_seen++;
    if (frame_err === 1'b1) err_seen++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    ref_a = '0; ref_b = '0; ref_buf = '0;
    ref_spd = 1'b0; ref_pwr = 1'b0; ref_word = '0;
  endtask

  task automatic model_apply(input logic [15:0] w);
    ref_word = w;
    ref_spd  = w[14];
    ref_pwr  = w[13];
    case ({w[15], w[12]})
      2'b00: begin ref_b = w[11:0]; ref_buf = w[11:0]; end
      2'b01: ref_buf = w[11:0];
      2'b10: begin ref_a = w[11:0]; ref_b = ref_buf; end
      default: ;
    endcase
    exp_frames++;
  endtask

  // Sends nbits from data (MSB first); optionally raises CS together with the last SCLK fall
  task automatic send_bits(input logic [31:0] data, input int nbits, input int phase,
                           input int gap, input bit cs_with_last);
    dac_cs_n = 1'b0;
    wait_clks(phase);
    for (int i = nbits - 1; i >= 0; i--) begin
      dac_din  = data[i];
      dac_sclk = 1'b1;
      wait_clks(phase);
      dac_sclk = 1'b0;
      if (i == 0 && cs_with_last) dac_cs_n = 1'b1;
      wait_clks(phase);
      if (i == nbits - 1) begin
        checks++;
        if (rx_busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL busy_mid_frame got %b want 1", rx_busy);
        end
      end
    end
    dac_cs_n = 1'b1;
    wait_clks(gap);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; dac_cs_n = 1'b1; dac_sclk = 1'b0; dac_din = 1'b0;
    model_reset();
    wait_clks(5);
    sys_rst = 1'b0;
    wait_clks(4);
    checks++;
    if ({dac_a_code, dac_b_code, buf_code} !== 36'h0) begin
      errors++;
      $display("[TB] FAIL reset_codes got %h/%h/%h want 0", dac_a_code, dac_b_code, buf_code);
    end
    checks++;
    if ({frame_word, speed_fast, power_down, rx_busy} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_misc got word=%h spd=%b pwr=%b busy=%b want 0",
               frame_word, speed_fast, power_down, rx_busy);
    end
    checks++;
    if (valid_seen !== 0 || err_seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_pulses got v=%0d e=%0d want 0", valid_seen, err_seen);
    end
  endtask

  task automatic test_b_buf();
    int v0;
    v0 = valid_seen;
    send_bits({16'h0, 16'h4ABC}, 16, 6, 6, 1'b0);
    model_apply(16'h4ABC);
    checks++;
    if (valid_seen - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL b_buf_valid got %0d pulses want 1", valid_seen - v0);
    end
    checks++;
    if (dac_b_code !== 12'hABC || buf_code !== 12'hABC || dac_a_code !== 12'h000) begin
      errors++;
      $display("[TB] FAIL b_buf_codes got a=%h b=%h buf=%h want 000/ABC/ABC",
               dac_a_code, dac_b_code, buf_code);
    end
    checks++;
    if (speed_fast !== 1'b1 || power_down !== 1'b0 || frame_word !== 16'h4ABC) begin
      errors++;
      $display("[TB] FAIL b_buf_ctrl got spd=%b pwr=%b word=%h want 1/0/4ABC",
               speed_fast, power_down, frame_word);
    end
  endtask

  task automatic test_buf_xfer();
    send_bits({16'h0, 16'h1123}, 16, 6, 6, 1'b0);
    model_apply(16'h1123);
    checks++;
    if (buf_code !== 12'h123 || dac_b_code !== 12'hABC) begin
      errors++;
      $display("[TB] FAIL buf_only got buf=%h b=%h want 123/ABC", buf_code, dac_b_code);
    end
    send_bits({16'h0, 16'h8456}, 16, 6, 6, 1'b0);
    model_apply(16'h8456);
    checks++;
    if (dac_a_code !== 12'h456 || dac_b_code !== 12'h123 || buf_code !== 12'h123) begin
      errors++;
      $display("[TB] FAIL a_xfer got a=%h b=%h buf=%h want 456/123/123",
               dac_a_code, dac_b_code, buf_code);
    end
  endtask

  task automatic test_short_frame();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_bits({23'h0, 9'h1A5}, 9, 6, 6, 1'b0);
    exp_errs++;
    checks++;
    if (err_seen - e0 !== 1 || valid_seen - v0 !== 0) begin
      errors++;
      $display("[TB] FAIL short_pulses got err=%0d valid=%0d want 1/0", err_seen - e0, valid_seen - v0);
    end
    checks++;
    if ({dac_a_code, dac_b_code, buf_code, frame_word} !== {ref_a, ref_b, ref_buf, ref_word}) begin
      errors++;
      $display("[TB] FAIL short_regs got %h/%h/%h/%h want %h/%h/%h/%h", dac_a_code, dac_b_code,
               buf_code, frame_word, ref_a, ref_b, ref_buf, ref_word);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL short_idle got busy=%b want 0", rx_busy);
    end
  endtask

  task automatic test_extra_bits();
    int v0;
    v0 = valid_seen;
    send_bits({14'h0, 16'h2FFF, 2'b01}, 18, 6, 6, 1'b0);
    model_apply(16'h2FFF);
    checks++;
    if (valid_seen - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL extra_valid got %0d pulses want 1", valid_seen - v0);
    end
    checks++;
    if (power_down !== 1'b1 || frame_word !== 16'h2FFF || dac_b_code !== 12'hFFF
        || buf_code !== 12'hFFF || dac_a_code !== 12'h456) begin
      errors++;
      $display("[TB] FAIL extra_regs got pwr=%b word=%h a=%h b=%h buf=%h want 1/2FFF/456/FFF/FFF",
               power_down, frame_word, dac_a_code, dac_b_code, buf_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    dac_cs_n = 1'b0;
    wait_clks(6);
    for (int i = 0; i < 8; i++) begin
      dac_din = i[0]; dac_sclk = 1'b1; wait_clks(6);
      dac_sclk = 1'b0; wait_clks(6);
    end
    v0 = valid_seen; e0 = err_seen;
    sys_rst = 1'b1;
    wait_clks(3);
    sys_rst = 1'b0;
    model_reset();
    exp_frames = 0; exp_errs = 0;
    valid_base = valid_seen;
    wait_clks(6);
    dac_cs_n = 1'b1;
    wait_clks(8);
    checks++;
    if (valid_seen - v0 !== 0 || err_seen - e0 !== 0) begin
      errors++;
      $display("[TB] FAIL rst_mid_pulses got valid=%0d err=%0d want 0/0", valid_seen - v0, err_seen - e0);
    end
    checks++;
    if (dac_b_code !== 12'h000 || frame_word !== 16'h0000 || rx_busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid_state got b=%h word=%h busy=%b want 000/0000/0",
               dac_b_code, frame_word, rx_busy);
    end
    send_bits({16'h0, 16'h0001}, 16, 6, 6, 1'b0);
    model_apply(16'h0001);
    checks++;
    if (dac_b_code !== 12'h001 || valid_seen - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL rst_mid_after got b=%h valid=%0d want 001/1", dac_b_code, valid_seen - v0);
    end
  endtask

  task automatic test_simultaneous();
    int v0, e0;
    v0 = valid_seen; e0 = err_seen;
    send_bits({16'h0, 16'h8321}, 16, 6, 6, 1'b1);
    model_apply(16'h8321);
    checks++;
    if (valid_seen - v0 !== 1 || err_seen - e0 !== 0 || dac_a_code !== 12'h321 || dac_b_code !== 12'h001) begin
      errors++;
      $display("[TB] FAIL simul_full got valid=%0d err=%0d a=%h b=%h want 1/0/321/001",
               valid_seen - v0, err_seen - e0, dac_a_code, dac_b_code);
    end
    send_bits({23'h0, 9'h0F3}, 9, 6, 6, 1'b1);
    exp_errs++;
    checks++;
    if (err_seen - e0 !== 1 || valid_seen - v0 !== 1) begin
      errors++;
      $display("[TB] FAIL simul_short got err=%0d valid=%0d want 1/1", err_seen - e0, valid_seen - v0);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        send_bits({27'h0, 5'h15}, 5, 4, 4, 1'b0);
        exp_errs++;
      end
      w = 16'($urandom);
      send_bits({16'h0, w}, 16, 4, 4, 1'b0);
      model_apply(w);
      checks++;
      if ({dac_a_code, dac_b_code, buf_code, speed_fast, power_down, frame_word}
          !== {ref_a, ref_b, ref_buf, ref_spd, ref_pwr, ref_word}) begin
        errors++;
        $display("[TB] FAIL b2b_frame%0d word=%h got a=%h b=%h buf=%h spd=%b pwr=%b fw=%h want %h/%h/%h/%b/%b/%h",
                 k, w, dac_a_code, dac_b_code, buf_code, speed_fast, power_down, frame_word,
                 ref_a, ref_b, ref_buf, ref_spd, ref_pwr, ref_word);
      end
    end
    checks++;
    if (valid_seen - valid_base !== exp_frames) begin
      errors++;
      $display("[TB] FAIL b2b_valid_count got %0d want %0d", valid_seen - valid_base, exp_frames);
    end
`ifdef TLV5618_RX_STATS_EN
    checks++;
    if (frame_cnt !== 16'(exp_frames) || err_cnt !== 8'(exp_errs)) begin
      errors++;
      $display("[TB] FAIL stats got frames=%0d errs=%0d want %0d/%0d", frame_cnt, err_cnt, exp_frames, exp_errs);
    end
`endif
  endtask

  initial begin
    $display("[TB] starting tlv5618_serial_rx bench");
    test_reset();
    test_b_buf();
    test_buf_xfer();
    test_short_frame();
    test_extra_bits();
    test_reset_mid_frame();
    test_simultaneous();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
